// File: rtl/rv_alu_pipeline_param_if.sv
// Instruction handshake bundle for rv_alu_pipeline_param.
//   instr        : 32-bit instruction word (held stable while valid && !ready)
//   instr_valid  : instr carries a real instruction this cycle
//   instr_ready  : pipeline accepts; transfer on valid && ready at a rising edge
interface rv_alu_pipeline_param_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;

  modport master (output instr, output instr_valid, input  instr_ready);
  modport slave  (input  instr, input  instr_valid, output instr_ready);
endinterface

// File: rtl/rv_alu_pipeline_param.sv
// Parametrised in-order integer execute pipeline (ID -> EX -> WB) for RV32I/RV64I
// register-register, register-immediate ALU ops and LUI.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : instruction valid/ready handshake (slave side)
//   dbg_addr  : debug register index
//   dbg_data  : GPR[dbg_addr], raw array read; 0 for x0 or index >= NREG
//   flags     : {Z,N,C,V}
//   illegal   : sticky, set when an unsupported instruction retires
//   retired   : count of retired legal instructions (wraps)
module rv_alu_pipeline_param #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int FWD_EN = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  rv_alu_pipeline_param_if.slave bus,
  input  logic [4:0]             dbg_addr,
  output logic [XLEN-1:0]        dbg_data,
  output logic [3:0]             flags,
  output logic                   illegal,
  output logic [31:0]            retired
);
  localparam int SHW    = $clog2(XLEN);
  localparam int RW     = $clog2(NREG);
  localparam int STAGES = 1;   // vld_pipe[0] = ID, vld_pipe[1] = EX

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_LUI
  } op_e;
  // Which flags an op touches when it leaves EX.
  typedef enum logic [1:0] {FC_NONE, FC_ARITH, FC_LOGIC} fcls_e;

  logic [XLEN-1:0] gpr [NREG];
  logic [STAGES:0] vld_pipe;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] ex_res;
  logic [4:0]      ex_rd;      // forced to 0 for illegal ops so they never write or forward
  logic            ex_ill;
  fcls_e           ex_cls;
  logic            ex_c, ex_v;

  // ---------------- ID: decode ----------------
  logic [6:0] opc, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  assign opc = id_instr[6:0];
  assign rd  = id_instr[11:7];
  assign f3  = id_instr[14:12];
  assign rs1 = id_instr[19:15];
  assign rs2 = id_instr[24:20];
  assign f7  = id_instr[31:25];

  // Immediate shifts: bit 30 picks SRA; everything above the shamt field except
  // bit 30 must be zero (covers instr[25]==0 on RV32, ignores funct7[0] on RV64).
  logic sh_ok;
  assign sh_ok = !id_instr[31] && (id_instr[29:20+SHW] == '0);

  op_e  op;
  logic dec_ok, use_rs1, use_rs2, use_imm, legal;

  always_comb begin
    op      = OP_ADD;
    dec_ok  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_imm = 1'b0;
    case (opc)
      7'b0110011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        if (f7 == 7'b0000000) begin
          dec_ok = 1'b1;
          case (f3)
            3'd0:    op = OP_ADD;
            3'd1:    op = OP_SLL;
            3'd2:    op = OP_SLT;
            3'd3:    op = OP_SLTU;
            3'd4:    op = OP_XOR;
            3'd5:    op = OP_SRL;
            3'd6:    op = OP_OR;
            default: op = OP_AND;
          endcase
        end else if (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)) begin
          dec_ok = 1'b1;
          op     = (f3 == 3'd0) ? OP_SUB : OP_SRA;
        end
      end
      7'b0010011: begin
        use_rs1 = 1'b1;
        use_imm = 1'b1;
        dec_ok  = 1'b1;
        case (f3)
          3'd0:    op = OP_ADD;
          3'd2:    op = OP_SLT;
          3'd3:    op = OP_SLTU;
          3'd4:    op = OP_XOR;
          3'd6:    op = OP_OR;
          3'd7:    op = OP_AND;
          3'd1:    begin op = OP_SLL; dec_ok = sh_ok && !id_instr[30]; end
          default: begin op = id_instr[30] ? OP_SRA : OP_SRL; dec_ok = sh_ok; end
        endcase
      end
      7'b0110111: begin
        op     = OP_LUI;
        dec_ok = 1'b1;
      end
      default: ;
    endcase
  end

  function automatic logic idx_ok(input logic [4:0] i);
    return 32'(i) < NREG;
  endfunction

  assign legal = dec_ok && idx_ok(rd) && (!use_rs1 || idx_ok(rs1)) && (!use_rs2 || idx_ok(rs2));

  // ---------------- ID: hazards, operands ----------------
  logic ex_wr, hit1, hit2, stall;
  assign ex_wr = vld_pipe[1] && (ex_rd != 5'd0);
  assign hit1  = ex_wr && (ex_rd == rs1);
  assign hit2  = ex_wr && (ex_rd == rs2);
  // Without forwarding, a RAW on the EX producer holds ID for the single cycle
  // it takes the producer to reach the register file.
  assign stall = (FWD_EN == 0) && vld_pipe[0] && legal &&
                 ((use_rs1 && hit1) || (use_rs2 && hit2));
  assign bus.instr_ready = !rst && !stall;

  logic [XLEN-1:0] rs1_val, rs2_val, imm, lui, opb;
  assign rs1_val = (rs1 == 5'd0) ? '0 : ((FWD_EN != 0 && hit1) ? ex_res : gpr[rs1[RW-1:0]]);
  assign rs2_val = (rs2 == 5'd0) ? '0 : ((FWD_EN != 0 && hit2) ? ex_res : gpr[rs2[RW-1:0]]);
  assign imm     = XLEN'($signed(id_instr[31:20]));
  assign lui     = XLEN'($signed({id_instr[31:12], 12'b0}));
  assign opb     = use_imm ? imm : rs2_val;

  // ---------------- ID: ALU ----------------
  logic [SHW-1:0]  shamt;
  logic [XLEN:0]   sum, dif;
  logic [XLEN-1:0] res;
  logic            alu_c, alu_v;
  fcls_e           alu_cls;

  assign shamt = opb[SHW-1:0];
  assign sum   = {1'b0, rs1_val} + {1'b0, opb};
  assign dif   = {1'b0, rs1_val} + {1'b0, ~opb} + {{XLEN{1'b0}}, 1'b1};

  always_comb begin
    res     = sum[XLEN-1:0];
    alu_c   = sum[XLEN];
    alu_v   = (rs1_val[XLEN-1] == opb[XLEN-1]) && (sum[XLEN-1] != rs1_val[XLEN-1]);
    alu_cls = FC_LOGIC;
    case (op)
      OP_ADD:  alu_cls = FC_ARITH;
      OP_SUB: begin
        res     = dif[XLEN-1:0];
        alu_c   = dif[XLEN];
        alu_v   = (rs1_val[XLEN-1] != opb[XLEN-1]) && (dif[XLEN-1] != rs1_val[XLEN-1]);
        alu_cls = FC_ARITH;
      end
      OP_XOR:  res = rs1_val ^ opb;
      OP_OR:   res = rs1_val | opb;
      OP_AND:  res = rs1_val & opb;
      OP_SLL:  res = rs1_val << shamt;
      OP_SRL:  res = rs1_val >> shamt;
      OP_SRA:  res = XLEN'($signed(rs1_val) >>> shamt);
      OP_SLT: begin
        res     = {{(XLEN-1){1'b0}}, ($signed(rs1_val) < $signed(opb))};
        alu_cls = FC_NONE;
      end
      OP_SLTU: begin
        res     = {{(XLEN-1){1'b0}}, (rs1_val < opb)};
        alu_cls = FC_NONE;
      end
      default: res = lui;
    endcase
  end

  // ---------------- ID/EX/WB registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      id_instr <= '0;
      ex_res   <= '0;
      ex_rd    <= '0;
      ex_ill   <= 1'b0;
      ex_cls   <= FC_NONE;
      ex_c     <= 1'b0;
      ex_v     <= 1'b0;
      flags    <= '0;
      illegal  <= 1'b0;
      retired  <= '0;
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    end else begin
      if (bus.instr_ready) begin
        vld_pipe[0] <= bus.instr_valid;
        if (bus.instr_valid) id_instr <= bus.instr;
      end
      vld_pipe[1] <= vld_pipe[0] && !stall;
      ex_res      <= res;
      ex_rd       <= legal ? rd : 5'd0;
      ex_ill      <= !legal;
      ex_cls      <= legal ? alu_cls : FC_NONE;
      ex_c        <= alu_c;
      ex_v        <= alu_v;

      if (vld_pipe[1]) begin
        if (ex_ill) begin
          illegal <= 1'b1;
        end else begin
          retired <= retired + 32'd1;
          if (ex_rd != 5'd0) gpr[ex_rd[RW-1:0]] <= ex_res;
          if (ex_cls != FC_NONE) begin
            flags[3] <= (ex_res == '0);
            flags[2] <= ex_res[XLEN-1];
          end
          if (ex_cls == FC_ARITH) begin
            flags[1] <= ex_c;
            flags[0] <= ex_v;
          end
        end
      end
    end
  end

  assign dbg_data = (dbg_addr == 5'd0 || 32'(dbg_addr) >= NREG) ? '0 : gpr[dbg_addr[RW-1:0]];
endmodule

// File: tb/tb_rv_alu_pipeline_param.sv
// Directed bench: three instances (forwarding, interlock, RV-E register file)
// share clock/reset; sel routes the stimulus and observed outputs.
module tb_rv_alu_pipeline_param;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] d_instr = '0;
  logic        d_valid = 1'b0;
  logic [4:0]  dbg_addr = '0;
  int          sel = 0;
  int          checks = 0;
  int          failures = 0;
  int          stall_cnt = 0;

  always #10 clk = ~clk;

  rv_alu_pipeline_param_if if_a ();
  rv_alu_pipeline_param_if if_b ();
  rv_alu_pipeline_param_if if_c ();

  logic [31:0] dbg_a, dbg_b, dbg_c, ret_a, ret_b, ret_c;
  logic [3:0]  fl_a, fl_b, fl_c;
  logic        ill_a, ill_b, ill_c;

  assign if_a.instr = d_instr;  assign if_a.instr_valid = d_valid && (sel == 0);
  assign if_b.instr = d_instr;  assign if_b.instr_valid = d_valid && (sel == 1);
  assign if_c.instr = d_instr;  assign if_c.instr_valid = d_valid && (sel == 2);

  rv_alu_pipeline_param #(.XLEN(32), .NREG(32), .FWD_EN(1)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a), .dbg_addr(dbg_addr), .dbg_data(dbg_a),
    .flags(fl_a), .illegal(ill_a), .retired(ret_a));
  rv_alu_pipeline_param #(.XLEN(32), .NREG(32), .FWD_EN(0)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b), .dbg_addr(dbg_addr), .dbg_data(dbg_b),
    .flags(fl_b), .illegal(ill_b), .retired(ret_b));
  rv_alu_pipeline_param #(.XLEN(32), .NREG(16), .FWD_EN(1)) dut_c (
    .clk(clk), .rst(rst), .bus(if_c), .dbg_addr(dbg_addr), .dbg_data(dbg_c),
    .flags(fl_c), .illegal(ill_c), .retired(ret_c));

  logic        cur_ready, cur_ill;
  logic [31:0] cur_dbg, cur_ret;
  logic [3:0]  cur_fl;
  assign cur_ready = (sel == 0) ? if_a.instr_ready : (sel == 1) ? if_b.instr_ready : if_c.instr_ready;
  assign cur_dbg   = (sel == 0) ? dbg_a : (sel == 1) ? dbg_b : dbg_c;
  assign cur_ret   = (sel == 0) ? ret_a : (sel == 1) ? ret_b : ret_c;
  assign cur_fl    = (sel == 0) ? fl_a  : (sel == 1) ? fl_b  : fl_c;
  assign cur_ill   = (sel == 0) ? ill_a : (sel == 1) ? ill_b : ill_c;

  // Count cycles where the selected pipeline refuses input outside reset.
  always @(negedge clk) begin
    #1;
    if (!rst && !cur_ready) stall_cnt++;
  end

  function automatic logic [31:0] enc_i(input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'b0110111};
  endfunction

  // Present one instruction from a negedge and return at the negedge after it transfers.
  task automatic issue(input logic [31:0] w);
    int n;
    n = 0;
    d_instr = w;
    d_valid = 1'b1;
    #1;
    while (!cur_ready && n < 8) begin
      @(negedge clk); #1;
      n++;
    end
    if (!cur_ready) begin
      checks++; failures++;
      $display("FAIL issue_timeout instr=%h ready stuck at 0", w);
    end
    @(negedge clk);
    d_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    d_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic rd_reg(input logic [4:0] idx, output logic [31:0] v);
    dbg_addr = idx;
    #1;
    v = cur_dbg;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    d_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    sel = 0; rst = 1'b1; d_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({if_a.instr_ready, if_b.instr_ready, if_c.instr_ready} !== 3'b000) begin failures++; $display("FAIL reset_ready_low got=%b exp=000", {if_a.instr_ready, if_b.instr_ready, if_c.instr_ready}); end
    rst = 1'b0;
    #1;
    checks++; if ({if_a.instr_ready, if_b.instr_ready, if_c.instr_ready} !== 3'b111) begin failures++; $display("FAIL reset_ready_after got=%b exp=111", {if_a.instr_ready, if_b.instr_ready, if_c.instr_ready}); end
    checks++; if ({fl_a, ill_a, ret_a} !== 37'd0) begin failures++; $display("FAIL reset_outputs got=%h/%b/%0d exp=0/0/0", fl_a, ill_a, ret_a); end
    rd_reg(5'd1, v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL reset_gpr got=%h exp=0", v); end
  endtask

  task automatic test_back_to_back_fwd();
    logic [31:0] v;
    int s0;
    sel = 0; do_reset();
    s0 = stall_cnt;
    issue(enc_i(3'd0, 5'd1, 5'd0, 12'd5));
    issue(enc_i(3'd0, 5'd2, 5'd0, 12'hFFD));
    issue(enc_r(7'd0, 3'd0, 5'd3, 5'd1, 5'd2));
    idle(2);
    rd_reg(5'd3, v);
    checks++; if (v !== 32'd2) begin failures++; $display("FAIL fwd_x3 got=%h exp=%h", v, 32'd2); end
    rd_reg(5'd2, v);
    checks++; if (v !== 32'hFFFFFFFD) begin failures++; $display("FAIL fwd_x2 got=%h exp=fffffffd", v); end
    checks++; if (cur_fl !== 4'b0010) begin failures++; $display("FAIL fwd_flags got=%b exp=0010", cur_fl); end
    checks++; if (cur_ret !== 32'd3) begin failures++; $display("FAIL fwd_retired got=%0d exp=3", cur_ret); end
    checks++; if (stall_cnt - s0 !== 0) begin failures++; $display("FAIL fwd_no_stall got=%0d exp=0", stall_cnt - s0); end
  endtask

  task automatic test_latency();
    logic [31:0] v;
    sel = 0;
    issue(enc_i(3'd0, 5'd7, 5'd0, 12'd9));
    idle(1);
    rd_reg(5'd7, v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL latency_early got=%h exp=0", v); end
    idle(1);
    rd_reg(5'd7, v);
    checks++; if (v !== 32'd9) begin failures++; $display("FAIL latency_n2 got=%h exp=9", v); end
  endtask

  task automatic test_interlock();
    logic [31:0] v;
    int s0;
    sel = 1; do_reset();
    s0 = stall_cnt;
    issue(enc_i(3'd0, 5'd1, 5'd0, 12'd5));
    issue(enc_i(3'd0, 5'd2, 5'd0, 12'hFFD));
    issue(enc_r(7'd0, 3'd0, 5'd3, 5'd1, 5'd2));
    #1;
    checks++; if (cur_ready !== 1'b0) begin failures++; $display("FAIL stall_ready_low got=%b exp=0", cur_ready); end
    @(negedge clk); #1;
    checks++; if (cur_ready !== 1'b1) begin failures++; $display("FAIL stall_one_cycle got=%b exp=1", cur_ready); end
    idle(2);
    rd_reg(5'd3, v);
    checks++; if (v !== 32'd2) begin failures++; $display("FAIL stall_x3 got=%h exp=2", v); end
    checks++; if (cur_ret !== 32'd3) begin failures++; $display("FAIL stall_retired got=%0d exp=3", cur_ret); end
    checks++; if (stall_cnt - s0 !== 1) begin failures++; $display("FAIL stall_count got=%0d exp=1", stall_cnt - s0); end
  endtask

  task automatic test_flags();
    logic [31:0] v;
    sel = 0; do_reset();
    issue(enc_u(5'd1, 20'h80000));
    issue(enc_i(3'd0, 5'd1, 5'd1, 12'hFFF));
    issue(enc_i(3'd0, 5'd2, 5'd1, 12'd1));
    idle(2);
    rd_reg(5'd1, v);
    checks++; if (v !== 32'h7FFFFFFF) begin failures++; $display("FAIL flg_x1 got=%h exp=7fffffff", v); end
    rd_reg(5'd2, v);
    checks++; if (v !== 32'h80000000) begin failures++; $display("FAIL flg_x2 got=%h exp=80000000", v); end
    checks++; if (cur_fl !== 4'b0101) begin failures++; $display("FAIL flg_addi_ovf got=%b exp=0101", cur_fl); end
    issue(enc_r(7'b0100000, 3'd0, 5'd3, 5'd2, 5'd2));
    idle(2);
    rd_reg(5'd3, v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL flg_sub_x3 got=%h exp=0", v); end
    checks++; if (cur_fl !== 4'b1010) begin failures++; $display("FAIL flg_sub got=%b exp=1010", cur_fl); end
    issue(enc_i(3'd4, 5'd4, 5'd0, 12'd0));
    idle(2);
    checks++; if (cur_fl !== 4'b1010) begin failures++; $display("FAIL flg_xori got=%b exp=1010", cur_fl); end
    issue(enc_i(3'd5, 5'd5, 5'd2, 12'h404));
    idle(2);
    rd_reg(5'd5, v);
    checks++; if (v !== 32'hF8000000) begin failures++; $display("FAIL srai got=%h exp=f8000000", v); end
    checks++; if (cur_fl !== 4'b0110) begin failures++; $display("FAIL flg_srai got=%b exp=0110", cur_fl); end
    issue(enc_i(3'd5, 5'd5, 5'd2, 12'h004));
    idle(2);
    rd_reg(5'd5, v);
    checks++; if (v !== 32'h08000000) begin failures++; $display("FAIL srli got=%h exp=08000000", v); end
    checks++; if (cur_fl !== 4'b0010) begin failures++; $display("FAIL flg_srli got=%b exp=0010", cur_fl); end
    issue(enc_r(7'd0, 3'd3, 5'd6, 5'd0, 5'd2));
    issue(enc_r(7'd0, 3'd2, 5'd7, 5'd2, 5'd0));
    idle(2);
    rd_reg(5'd6, v);
    checks++; if (v !== 32'd1) begin failures++; $display("FAIL sltu got=%h exp=1", v); end
    rd_reg(5'd7, v);
    checks++; if (v !== 32'd1) begin failures++; $display("FAIL slt got=%h exp=1", v); end
    checks++; if (cur_fl !== 4'b0010) begin failures++; $display("FAIL flg_slt_hold got=%b exp=0010", cur_fl); end
    issue(enc_i(3'd0, 5'd0, 5'd1, 12'd1));
    idle(2);
    rd_reg(5'd0, v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL x0_hardwire got=%h exp=0", v); end
    checks++; if (cur_ret !== 32'd10) begin failures++; $display("FAIL flg_retired got=%0d exp=10", cur_ret); end
  endtask

  task automatic test_illegal();
    logic [31:0] v;
    sel = 2; do_reset();
    issue(enc_i(3'd0, 5'd1, 5'd0, 12'd4));
    issue(enc_i(3'd0, 5'd2, 5'd0, 12'd6));
    issue(enc_r(7'd0, 3'd0, 5'd17, 5'd1, 5'd2));
    idle(1);
    checks++; if ({cur_ill, cur_ret} !== {1'b0, 32'd2}) begin failures++; $display("FAIL ill_before got=%b/%0d exp=0/2", cur_ill, cur_ret); end
    idle(1);
    checks++; if ({cur_ill, cur_ret} !== {1'b1, 32'd2}) begin failures++; $display("FAIL ill_rd17 got=%b/%0d exp=1/2", cur_ill, cur_ret); end
    rd_reg(5'd17, v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL ill_dbg17 got=%h exp=0", v); end
    rd_reg(5'd1, v);
    checks++; if (v !== 32'd4) begin failures++; $display("FAIL ill_x1 got=%h exp=4", v); end
    checks++; if (cur_fl !== 4'b0000) begin failures++; $display("FAIL ill_flags got=%b exp=0000", cur_fl); end
    do_reset();
    issue(32'h0000_0000);
    idle(2);
    checks++; if ({cur_ill, cur_ret} !== {1'b1, 32'd0}) begin failures++; $display("FAIL ill_zero got=%b/%0d exp=1/0", cur_ill, cur_ret); end
    sel = 0; do_reset();
    issue(enc_r(7'b0100000, 3'd4, 5'd3, 5'd1, 5'd2));
    idle(2);
    checks++; if ({cur_ill, cur_ret} !== {1'b1, 32'd0}) begin failures++; $display("FAIL ill_funct got=%b/%0d exp=1/0", cur_ill, cur_ret); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] v;
    sel = 0; do_reset();
    issue(enc_i(3'd0, 5'd8, 5'd0, 12'd11));
    issue(enc_i(3'd0, 5'd9, 5'd0, 12'd12));
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (cur_ready !== 1'b0) begin failures++; $display("FAIL mid_ready_rst got=%b exp=0", cur_ready); end
    rst = 1'b0;
    #1;
    checks++; if (cur_ready !== 1'b1) begin failures++; $display("FAIL mid_ready_after got=%b exp=1", cur_ready); end
    checks++; if ({cur_fl, cur_ill, cur_ret} !== 37'd0) begin failures++; $display("FAIL mid_outputs got=%b/%b/%0d exp=0/0/0", cur_fl, cur_ill, cur_ret); end
    idle(3);
    rd_reg(5'd8, v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL mid_x8 got=%h exp=0", v); end
    rd_reg(5'd9, v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL mid_x9 got=%h exp=0", v); end
    checks++; if (cur_ret !== 32'd0) begin failures++; $display("FAIL mid_retired got=%0d exp=0", cur_ret); end
  endtask

  initial begin
    test_reset();
    test_back_to_back_fwd();
    test_latency();
    test_interlock();
    test_flags();
    test_illegal();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
